// File: rtl/light_pkg.sv
// Shared types for the traffic-light phase controller: FSM states, phase-index
// width and the cyclic demand search used when choosing the next green phase.
package light_pkg;

    localparam int PHASE_W    = 3;
    localparam int MAX_PHASES = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GREEN,
        ST_YELLOW,
        ST_ALLRED,
        ST_WALK
    } state_t;

    typedef struct packed {
        logic               found;
        logic [PHASE_W-1:0] idx;
    } pick_t;

    // First set bit of dem among the n lowest bits, scanning upward from start and wrapping.
    function automatic pick_t pick_next(input logic [MAX_PHASES-1:0] dem,
                                        input logic [PHASE_W-1:0]    start,
                                        input int                    n);
        pick_t r;
        int    j;
        r = '0;
        for (int k = 0; k < MAX_PHASES; k++) begin
            j = (int'(start) + k) % n;
            if (k < n && !r.found && dem[j]) begin
                r.found = 1'b1;
                r.idx   = PHASE_W'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/light_timer.sv
// Loadable down-counter that holds at zero; zero flag marks the terminal count.
module light_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          zero
);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - TW'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/light_phase_ctrl.sv
// Traffic-light phase sequencer: cyclic service of per-phase demand with
// green/yellow/all-red timing. Define LIGHT_PED_EN to add the pedestrian WALK phase.
//
// state     | meaning
// ST_IDLE   | all red, waiting for any demand
// ST_GREEN  | green on the served phase, minimum time then rest or yield
// ST_YELLOW | yellow on the served phase
// ST_ALLRED | all-red clearance, pointer advances on exit
// ST_WALK   | all red with walk lamp (LIGHT_PED_EN only)
module light_phase_ctrl
    import light_pkg::*;
#(
    parameter int N_PHASES   = 4,
    parameter int TW         = 8,
    parameter int GREEN_CYC  = 20,
    parameter int YELLOW_CYC = 4,
    parameter int ALLRED_CYC = 2,
    parameter int WALK_CYC   = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_PHASES-1:0] req,
    input  logic                ped_req,
    output logic [N_PHASES-1:0] green,
    output logic [N_PHASES-1:0] yellow,
    output logic [N_PHASES-1:0] red,
    output logic [PHASE_W-1:0]  phase,
    output logic                walk
);

    localparam longint DUR_MAX = longint'(1) << TW;

    if (N_PHASES < 1 || N_PHASES > MAX_PHASES) begin : g_bad_phases
        $error("light_phase_ctrl: N_PHASES must be in 1..8");
    end
    if (GREEN_CYC < 1 || GREEN_CYC >= DUR_MAX || YELLOW_CYC < 1 || YELLOW_CYC >= DUR_MAX ||
        ALLRED_CYC < 1 || ALLRED_CYC >= DUR_MAX || WALK_CYC < 1 || WALK_CYC >= DUR_MAX) begin : g_bad_dur
        $error("light_phase_ctrl: durations must satisfy 1 <= value < 2**TW");
    end

    state_t                 state, state_nxt;
    logic [PHASE_W-1:0]     ptr, ptr_after, search_start;
    logic [N_PHASES-1:0]    pend;
    logic [MAX_PHASES-1:0]  dem8, own_mask, clr8, lamp8;
    logic                   own_dem, other_dem, ped_pend, enter_green;
    logic                   t_zero, timer_load;
    logic [TW-1:0]          timer_val;
    pick_t                  pick;

    assign dem8      = MAX_PHASES'(pend | req);
    assign own_dem   = dem8[phase];
    // A single-phase intersection treats its own demand as a reason to cycle.
    assign own_mask  = (N_PHASES == 1) ? '0 : (MAX_PHASES'(1) << phase);
    assign other_dem = |(dem8 & ~own_mask);
    assign ptr_after = PHASE_W'((int'(phase) + 1) % N_PHASES);
    assign search_start = (state == ST_ALLRED) ? ptr_after : ptr;
    assign pick      = pick_next(dem8, search_start, N_PHASES);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pick.found) state_nxt = ST_GREEN;
            end
            // Rest only while the served phase still wants green and nobody else does.
            ST_GREEN: begin
                if (t_zero && (other_dem || ped_pend || !own_dem)) state_nxt = ST_YELLOW;
            end
            ST_YELLOW: begin
                if (t_zero) state_nxt = ST_ALLRED;
            end
            ST_ALLRED: begin
                if (t_zero) begin
                    state_nxt = pick.found ? ST_GREEN : ST_IDLE;
`ifdef LIGHT_PED_EN
                    if (ped_pend) state_nxt = ST_WALK;
`endif
                end
            end
`ifdef LIGHT_PED_EN
            ST_WALK: begin
                if (t_zero) state_nxt = pick.found ? ST_GREEN : ST_IDLE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        timer_load = (state_nxt != state);
        timer_val  = '0;
        case (state_nxt)
            ST_GREEN:  timer_val = TW'(GREEN_CYC - 1);
            ST_YELLOW: timer_val = TW'(YELLOW_CYC - 1);
            ST_ALLRED: timer_val = TW'(ALLRED_CYC - 1);
            ST_WALK:   timer_val = TW'(WALK_CYC - 1);
            default:   timer_val = '0;
        endcase
    end

    assign enter_green = (state_nxt == ST_GREEN) && (state != ST_GREEN);
    assign clr8        = enter_green ? (MAX_PHASES'(1) << pick.idx) : '0;

    light_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (t_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            ptr   <= '0;
            phase <= '0;
            pend  <= '0;
        end else begin
            state <= state_nxt;
            pend  <= (pend | req) & ~clr8[N_PHASES-1:0];
            if (enter_green) phase <= pick.idx;
            if (state == ST_ALLRED && t_zero) ptr <= ptr_after;
        end
    end

`ifdef LIGHT_PED_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ped_pend <= 1'b0;
        end else if (state_nxt == ST_WALK && state != ST_WALK) begin
            ped_pend <= 1'b0;
        end else if (ped_req) begin
            ped_pend <= 1'b1;
        end
    end

    assign walk = (state == ST_WALK);
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
    assign ped_pend       = 1'b0;
    assign walk           = 1'b0;
`endif

    assign lamp8 = MAX_PHASES'(1) << phase;

    always_comb begin
        green  = '0;
        yellow = '0;
        if (state == ST_GREEN)  green  = lamp8[N_PHASES-1:0];
        if (state == ST_YELLOW) yellow = lamp8[N_PHASES-1:0];
    end

    assign red = ~(green | yellow);

endmodule

// File: tb/tb_light_phase_ctrl.sv
// Directed self-checking bench for light_phase_ctrl with default parameters.
module tb_light_phase_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       ped_req = 1'b0;
    logic [3:0] green, yellow, red;
    logic [2:0] phase;
    logic       walk;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    light_phase_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ped_req (ped_req),
        .green   (green),
        .yellow  (yellow),
        .red     (red),
        .phase   (phase),
        .walk    (walk)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        ped_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        req = 4'b0000;
        ped_req = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (red !== 4'b1111 || green !== 4'b0000 || yellow !== 4'b0000 || phase !== 3'd0 || walk !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: red=%b green=%b yellow=%b phase=%0d walk=%b, want 1111 0000 0000 0 0",
                     red, green, yellow, phase, walk);
        end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (red !== 4'b1111 || green !== 4'b0000 || walk !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL idle_quiet: %0d bad cycles, want 0", bad);
        end
    endtask

    task automatic test_single_pulse();
        int bad;
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (green !== 4'b0100 || phase !== 3'd2 || yellow !== 4'b0000) bad++;
            @(negedge clk);
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL pulse_green: %0d bad cycles, want 0", bad); end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (yellow !== 4'b0100 || green !== 4'b0000) bad++;
            @(negedge clk);
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL pulse_yellow: %0d bad cycles, want 0", bad); end
        bad = 0;
        for (int i = 0; i < 2; i++) begin
            if (red !== 4'b1111) bad++;
            @(negedge clk);
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL pulse_allred: %0d bad cycles, want 0", bad); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (red !== 4'b1111 || walk !== 1'b0) bad++;
            @(negedge clk);
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL pulse_idle: %0d bad cycles, want 0", bad); end
    endtask

    task automatic test_rotation();
        int exp_seq [4];
        int cnt;
        int len;
        logic [3:0] exp_lamp;
        exp_seq = '{0, 1, 3, 0};
        rst = 1'b1;
        req = 4'b1011;
        ped_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int p = 0; p < 4; p++) begin
            cnt = 0;
            while (green === 4'b0000 && cnt < 200) begin
                @(negedge clk);
                cnt++;
            end
            exp_lamp = 4'(1 << exp_seq[p]);
            tests++;
            if (phase !== 3'(exp_seq[p]) || green !== exp_lamp) begin
                fails++;
                $display("FAIL rotation_phase[%0d]: phase=%0d green=%b, want phase=%0d green=%b",
                         p, phase, green, exp_seq[p], exp_lamp);
            end
            len = 0;
            while (green !== 4'b0000 && len < 200) begin
                @(negedge clk);
                len++;
            end
            tests++;
            if (len != 20) begin
                fails++;
                $display("FAIL rotation_len[%0d]: green lasted %0d cycles, want 20", p, len);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_hold_rest();
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        repeat (30) @(negedge clk);
        tests++;
        if (green !== 4'b0100 || yellow !== 4'b0000) begin
            fails++;
            $display("FAIL rest_green: green=%b yellow=%b, want 0100 0000", green, yellow);
        end
        req = 4'b0101;
        @(negedge clk);
        tests++;
        if (yellow !== 4'b0100 || green !== 4'b0000) begin
            fails++;
            $display("FAIL rest_exit_yellow: yellow=%b green=%b, want 0100 0000", yellow, green);
        end
        repeat (4) @(negedge clk);
        tests++;
        if (red !== 4'b1111) begin
            fails++;
            $display("FAIL rest_allred: red=%b, want 1111", red);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (green !== 4'b0001 || phase !== 3'd0) begin
            fails++;
            $display("FAIL rest_next_green: green=%b phase=%0d, want 0001 0", green, phase);
        end
        req = 4'b0000;
    endtask

    task automatic test_reset_in_yellow();
        int cnt;
        int bad;
        do_reset();
        req = 4'b0110;
        @(negedge clk);
        req = 4'b0000;
        cnt = 0;
        while (yellow === 4'b0000 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        tests++;
        if (yellow !== 4'b0010 || phase !== 3'd1) begin
            fails++;
            $display("FAIL yellow_reached: yellow=%b phase=%0d, want 0010 1", yellow, phase);
        end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (red !== 4'b1111 || green !== 4'b0000 || yellow !== 4'b0000 || phase !== 3'd0 || walk !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_yellow: red=%b green=%b yellow=%b phase=%0d walk=%b, want 1111 0000 0000 0 0",
                     red, green, yellow, phase, walk);
        end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (green !== 4'b0000 || red !== 4'b1111) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL no_green_after_reset: %0d bad cycles, want 0", bad);
        end
    endtask

    task automatic test_ped();
        int cnt;
        int len;
        int bad;
        do_reset();
`ifdef LIGHT_PED_EN
        req = 4'b0010;
        @(negedge clk);
        req = 4'b0000;
        repeat (5) @(negedge clk);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        cnt = 0;
        while (yellow === 4'b0000 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        repeat (6) @(negedge clk);
        tests++;
        if (walk !== 1'b1 || red !== 4'b1111) begin
            fails++;
            $display("FAIL walk_start: walk=%b red=%b, want 1 1111", walk, red);
        end
        len = 0;
        while (walk === 1'b1 && red === 4'b1111 && len < 50) begin
            @(negedge clk);
            len++;
        end
        tests++;
        if (len != 10) begin
            fails++;
            $display("FAIL walk_len: walk lasted %0d cycles, want 10", len);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (walk !== 1'b0 || red !== 4'b1111) bad++;
            @(negedge clk);
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL walk_to_idle: %0d bad cycles, want 0", bad); end
`else
        ped_req = 1'b1;
        req = 4'b0010;
        @(negedge clk);
        ped_req = 1'b0;
        req = 4'b0000;
        bad = 0;
        len = 0;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (walk !== 1'b0) bad++;
            if (green === 4'b0010) len++;
            @(negedge clk);
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL walk_tied_low: %0d cycles with walk=1, want 0", bad); end
        tests++;
        if (len != 20) begin fails++; $display("FAIL ped_ignored_green: green lasted %0d cycles, want 20", len); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_rotation();
        test_hold_rest();
        test_reset_in_yellow();
        test_ped();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
